fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised synchronous single-clock FIFO. Successor to the fixed 8-bit full/empty FIFO, adding:
- configurable width and depth
- occupancy count
- programmable almost-full / almost-empty thresholds
- registered read data with a valid strobe
- overflow / underflow error pulses
- defined simultaneous read/write behaviour, including at full.

It is the general buffering element between producer and consumer blocks in the sequential-circuits library.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-low: state resets on a rising clk edge while rst==0
w_en  in  1  write request
in_data  in  DATA_W  write data, sampled at the edge where a write is accepted
r_en  in  1  read request
out_data  out  DATA_W  registered read data
rd_valid  out  1  high for one cycle when out_data holds a newly read word
full  out  1  count==DEPTH
empty  out  1  count==0
almost_full  out  1  count>=AF_THRESH
almost_empty  out  1  count<=AE_THRESH
count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst==0 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, out_data=0
  - rd_valid=0, overflow=0, underflow=0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - Memory contents are not cleared.
  - Reset overrides any w_en/r_en in that cycle; a reset mid-stream discards all stored data.
- Pointers are clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0. count is maintained separately (no pointer-difference arithmetic).
- Read accept: rd_acc = r_en && !empty.
  - On accept: out_data <= mem[rd_ptr], rd_ptr+1, rd_valid<=1 on the same edge.
  - Read latency: data is visible one edge after the request.
  - Otherwise rd_valid<=0 and out_data holds its value.
- Write accept: wr_acc = w_en && (!full || rd_acc).
  - On accept: mem[wr_ptr] <= in_data, wr_ptr+1.
  - At full, a simultaneous write and read are both accepted; count stays DEPTH.
- No bypass: at empty, simultaneous r_en and w_en accepts the write only. The read is rejected and underflow pulses; count becomes 1.
- count update: +1 for write-only, -1 for read-only, unchanged for both or neither.
- All flags are registered, derived from the next-state count, and change on the same edge as count.
- overflow <= w_en && !wr_acc; underflow <= r_en && !rd_acc. Each is a one-cycle pulse per rejected request. Rejected requests change no other state.
- Elaboration error if DEPTH is not a power of 2 or either threshold is out of range.

Decomposition:
- Package fifo_pkg: clog2 function, default DATA_W/DEPTH constants.
- One sub-module fifo_mem: simple dual-port RAM, DEPTH x DATA_W, synchronous write, synchronous registered read port. It drives out_data.
- Pointer, count and flag logic stay in fifo_sync_param.

Test Plan:
All scenarios use DATA_W=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1.
1. Reset, then write 0xA1,0xB2,0xC3,0xD4 on consecutive cycles:
   - count steps 1,2,3,4
   - empty falls after the 1st write; almost_empty falls after the 2nd
   - almost_full rises after the 3rd; full rises after the 4th
   - no overflow
2. From full, hold w_en with 0xEE for 1 cycle: overflow pulses one cycle, count stays 4, the stored data is unchanged.
3. From full, read 4 times:
   - out_data = 0xA1,0xB2,0xC3,0xD4, each with rd_valid one edge after its r_en
   - empty=1 after the 4th read
   - a 5th read gives an underflow pulse and rd_valid=0
4. Wrap-around: write 3 words, read 2, write 3, read 4: data comes out in FIFO order across the pointer wrap; count ends at 0.
5. Simultaneous operations:
   - At full, w_en=r_en=1 with 0x55: oldest word is read, count stays 4, 0x55 is read out last.
   - At empty, w_en=r_en=1: underflow pulses and count becomes 1.
6. Reset mid-stream: with count=2, drive rst=0 for one edge while w_en=1. Then count=0, empty=1, rd_valid=0, and a following read gives underflow.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the synchronous FIFO family.
//               c_DEFAULT_DATA_W / c_DEFAULT_DEPTH : default geometry
//               clog2()                            : ceiling log2 for sizing
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DEFAULT_DATA_W = 8;
    localparam int c_DEFAULT_DEPTH  = 16;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(16) = 4.
    function automatic int clog2(input int value);
        int r_bits;
        int r_rem;
        r_bits = 0;
        r_rem  = value - 1;
        while (r_rem > 0) begin
            r_bits = r_bits + 1;
            r_rem  = r_rem >> 1;
        end
        return r_bits;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : Simple dual-port RAM, DEPTH x DATA_W. Synchronous write port,
//               synchronous read port with a registered output that holds its
//               value when no read is issued.
// Ports       : clk      - clock
//               rst      - synchronous active-low reset (read register only)
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable
//               i_raddr  - read address
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full/almost-empty thresholds, registered
//               read data with valid strobe and overflow/underflow pulses.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous reset, active-low
//               w_en/in_data - write request and data
//               r_en         - read request
//               out_data     - registered read data
//               rd_valid     - out_data holds a newly read word
//               full/empty/almost_full/almost_empty - registered flags
//               count        - occupancy 0..DEPTH
//               overflow     - one-cycle pulse: write rejected
//               underflow    - one-cycle pulse: read rejected
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = c_DEFAULT_DATA_W,
    parameter int DEPTH     = c_DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_en,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   r_en,
    output logic [DATA_W-1:0]      out_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_AF_CNT    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] c_AE_CNT    = CNT_W'(AE_THRESH);

    // Elaboration-time parameter checks.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of 2 and >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("fifo_sync_param: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("fifo_sync_param: AE_THRESH must be in 0..DEPTH-1");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("fifo_sync_param: DATA_W must be >= 1");
    end

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [CNT_W-1:0]  w_count_nxt;

    // A read frees a slot on the same edge, so a write at full is accepted
    // when paired with a read. At empty there is no bypass: the read fails.
    assign w_rd_acc = r_en && !r_empty;
    assign w_wr_acc = w_en && (!r_full || w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_rd_valid     <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count        <= w_count_nxt;
            // Flags are taken from the next count so they move with count.
            r_full         <= (w_count_nxt == c_DEPTH_CNT);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_AF_CNT);
            r_almost_empty <= (w_count_nxt <= c_AE_CNT);
            r_rd_valid     <= w_rd_acc;
            r_overflow     <= w_en && !w_wr_acc;
            r_underflow    <= r_en && !w_rd_acc;
        end
    end

    // Writes are masked during reset so a reset edge never touches storage.
    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc && rst),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (out_data)
    );

    assign rd_valid     = r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : fifo_sync_param
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_param
// Description : Directed self-checking bench for fifo_sync_param
//               (DATA_W=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1) with a data
//               scoreboard and a behavioural occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] out_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;

    fifo_sync_param #(
        .DATA_W    (DW),
        .DEPTH     (DP),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .in_data      (in_data),
        .r_en         (r_en),
        .out_data     (out_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb [$];
    int            m_count = 0;
    logic [DW-1:0] m_out = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit exp_v, input bit exp_ov, input bit exp_un);
        logic [DW-1:0] w_exp;
        chk("count",        32'(count),        32'(m_count));
        chk("empty",        32'(empty),        32'(m_count == 0));
        chk("full",         32'(full),         32'(m_count == DP));
        chk("almost_full",  32'(almost_full),  32'(m_count >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(m_count <= AE));
        chk("rd_valid",     32'(rd_valid),     32'(exp_v));
        chk("overflow",     32'(overflow),     32'(exp_ov));
        chk("underflow",    32'(underflow),    32'(exp_un));
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underrun: observed data %0h expected no valid word", out_data);
            end else begin
                w_exp = sb.pop_front();
                m_out = w_exp;
                chk("out_data", 32'(out_data), 32'(w_exp));
            end
        end else begin
            chk("out_data_hold", 32'(out_data), 32'(m_out));
        end
    endtask

    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        bit rd_acc;
        bit wr_acc;
        @(negedge clk);
        w_en    = w;
        in_data = d;
        r_en    = r;
        rd_acc  = r && (m_count > 0);
        wr_acc  = w && ((m_count < DP) || rd_acc);
        if (wr_acc) sb.push_back(d);
        m_count = m_count + int'(wr_acc) - int'(rd_acc);
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        check_all(rd_acc, w && !wr_acc, r && !rd_acc);
    endtask

    task automatic do_reset(input bit wen);
        @(negedge clk);
        rst     = 1'b0;
        w_en    = wen;
        r_en    = 1'b0;
        in_data = 8'h99;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        w_en    = 1'b0;
        m_count = 0;
        m_out   = '0;
        sb.delete();
        check_all(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // 1. reset and fill
        do_reset(1'b0);
        step(1, 8'hA1, 0);
        step(1, 8'hB2, 0);
        step(1, 8'hC3, 0);
        step(1, 8'hD4, 0);
        chk("full_after_fill", 32'(full), 32'd1);

        // 2. overflow at full, stored data must survive
        step(1, 8'hEE, 0);

        // 3. drain, then underflow
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        chk("empty_after_drain", 32'(empty), 32'd1);
        step(0, 8'h00, 1);

        // 4. pointer wrap-around
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h03, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        step(1, 8'h04, 0);
        step(1, 8'h05, 0);
        step(1, 8'h06, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        chk("count_after_wrap", 32'(count), 32'd0);

        // 5a. simultaneous read/write at full
        step(1, 8'h10, 0);
        step(1, 8'h11, 0);
        step(1, 8'h12, 0);
        step(1, 8'h13, 0);
        step(1, 8'h55, 1);
        chk("count_full_rw", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);

        // 5b. simultaneous read/write at empty: write only
        step(1, 8'h66, 1);
        chk("count_empty_rw", 32'(count), 32'd1);
        step(0, 8'h00, 1);

        // 6. reset mid-stream with a write pending
        step(1, 8'h77, 0);
        step(1, 8'h88, 0);
        chk("count_before_rst", 32'(count), 32'd2);
        do_reset(1'b1);
        step(0, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_sync_param
`default_nettype wire
